// File: rtl/uart_cfg.sv
// Runtime-configurable UART (7/8 data bits, N/E/O parity, 1/2 stop bits) with RX/TX byte FIFOs.
// Optional UART_LOOPBACK_EN adds a loopback input that feeds the registered tx into the RX path.
//
// state   | meaning
// IDLE    | RX: waiting for a low line / TX: waiting for a byte in the TX FIFO
// START   | RX: half-bit start check / TX: driving the start bit
// DATA    | data bits, LSB first
// PAR     | parity bit
// STOP    | RX: stop-bit sample and FIFO write / TX: driving stop bit(s)
// STOP2   | RX only: second stop bit hold-off

module uart_fifo #(
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] w_data,
  input  logic       rd,
  output logic [7:0] r_data,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [2**W];
  logic [W-1:0] wp, rp;
  logic [W:0] cnt;
  logic do_wr, do_rd;

  assign full   = (cnt == (W+1)'(2**W));
  assign empty  = (cnt == '0);
  assign do_wr  = wr && (!full || rd);
  assign do_rd  = rd && !empty;
  assign r_data = empty ? 8'h00 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + W'(1);
      if (do_rd) rp <= rp + W'(1);
      cnt <= cnt + (W+1)'(do_wr) - (W+1)'(do_rd);
    end
  end
endmodule

module uart_cfg #(
  parameter int FIFO_W = 2,
  parameter int DIV_W  = 16,
  parameter int OVS    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             data7,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             rd_uart,
  input  logic             wr_uart,
  input  logic [7:0]       w_data,
  input  logic             rx,
`ifdef UART_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             tx,
  output logic             tx_full,
  output logic             rx_empty,
  output logic [7:0]       r_data,
  input  logic             err_clr,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_overrun
);
  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] HALF = SW'(OVS / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_STOP2} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  // Down-counter reloads at terminal count, so a new divisor applies from the next wrap.
  logic [DIV_W-1:0] baud_cnt;
  logic tick;
  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     baud_cnt <= '0;
    else if (tick) baud_cnt <= (divisor == '0) ? '0 : divisor - DIV_W'(1);
    else           baud_cnt <= baud_cnt - DIV_W'(1);
  end

  logic tx_reg, rx_src, rx_s1, rx_s2;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_reg : rx;
  assign tx     = loopback ? 1'b1 : tx_reg;
`else
  assign rx_src = rx;
  assign tx     = tx_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_src;
      rx_s2 <= rx_s1;
    end
  end

  rx_state_t rx_st;
  logic [SW-1:0] rx_cnt;
  logic [2:0] rx_n;
  logic [7:0] rx_sh, rx_byte;
  logic rx_par, rx_d7, rx_pe, rx_po, rx_2s, rx_wr, rx_full;

  // 7-bit frames shift one position short, leaving the data in the upper bits.
  assign rx_byte = rx_d7 ? {1'b0, rx_sh[7:1]} : rx_sh;
  assign rx_wr   = (rx_st == R_STOP) && tick && (rx_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_n   <= '0;
      rx_sh  <= '0;
      rx_par <= 1'b0;
      rx_d7  <= 1'b0;
      rx_pe  <= 1'b0;
      rx_po  <= 1'b0;
      rx_2s  <= 1'b0;
    end else begin
      case (rx_st)
        R_IDLE: if (!rx_s2) begin
          rx_st  <= R_START;
          rx_cnt <= '0;
          rx_d7  <= data7;
          rx_pe  <= parity_en;
          rx_po  <= parity_odd;
          rx_2s  <= two_stop;
        end
        R_START: if (tick) begin
          if (rx_cnt == HALF) begin
            rx_st  <= rx_s2 ? R_IDLE : R_DATA;
            rx_cnt <= '0;
            rx_n   <= '0;
          end else rx_cnt <= rx_cnt + SW'(1);
        end
        R_DATA: if (tick) begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_n == (rx_d7 ? 3'd6 : 3'd7)) rx_st <= rx_pe ? R_PAR : R_STOP;
            else                                rx_n  <= rx_n + 3'd1;
          end else rx_cnt <= rx_cnt + SW'(1);
        end
        R_PAR: if (tick) begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_par <= rx_s2;
            rx_st  <= R_STOP;
          end else rx_cnt <= rx_cnt + SW'(1);
        end
        R_STOP: if (tick) begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_st  <= rx_2s ? R_STOP2 : R_IDLE;
          end else rx_cnt <= rx_cnt + SW'(1);
        end
        R_STOP2: if (tick) begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_st  <= R_IDLE;
          end else rx_cnt <= rx_cnt + SW'(1);
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Error flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= (rx_frame_err & ~err_clr) | (rx_wr & ~rx_s2);
      rx_parity_err <= (rx_parity_err & ~err_clr) |
                       (rx_wr & rx_pe & (rx_par != ((^rx_byte) ^ rx_po)));
      rx_overrun    <= (rx_overrun & ~err_clr) | (rx_wr & rx_full & ~rd_uart);
    end
  end

  uart_fifo #(.W(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_wr), .w_data(rx_byte), .rd(rd_uart),
    .r_data(r_data), .full(rx_full), .empty(rx_empty)
  );

  tx_state_t tx_st;
  logic [SW-1:0] tx_cnt;
  logic [2:0] tx_n;
  logic [7:0] tx_sh, tx_head, tx_head_m;
  logic tx_par, tx_d7, tx_pe, tx_2s, tx_empty, tx_pop;

  assign tx_pop    = (tx_st == T_IDLE) && !tx_empty;
  assign tx_head_m = data7 ? {1'b0, tx_head[6:0]} : tx_head;

  uart_fifo #(.W(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .w_data(w_data), .rd(tx_pop),
    .r_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // Each bit is driven on the first tick of its period and held for OVS ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_n   <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
      tx_d7  <= 1'b0;
      tx_pe  <= 1'b0;
      tx_2s  <= 1'b0;
      tx_reg <= 1'b1;
    end else begin
      case (tx_st)
        T_IDLE: if (tx_pop) begin
          tx_sh  <= tx_head;
          tx_par <= (^tx_head_m) ^ parity_odd;
          tx_d7  <= data7;
          tx_pe  <= parity_en;
          tx_2s  <= two_stop;
          tx_cnt <= '0;
          tx_n   <= '0;
          tx_st  <= T_START;
        end
        T_START: if (tick) begin
          if (tx_cnt == '0) tx_reg <= 1'b0;
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_st  <= T_DATA;
          end else tx_cnt <= tx_cnt + SW'(1);
        end
        T_DATA: if (tick) begin
          if (tx_cnt == '0) tx_reg <= tx_sh[0];
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            if (tx_n == (tx_d7 ? 3'd6 : 3'd7)) begin
              tx_n  <= '0;
              tx_st <= tx_pe ? T_PAR : T_STOP;
            end else tx_n <= tx_n + 3'd1;
          end else tx_cnt <= tx_cnt + SW'(1);
        end
        T_PAR: if (tick) begin
          if (tx_cnt == '0) tx_reg <= tx_par;
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_st  <= T_STOP;
          end else tx_cnt <= tx_cnt + SW'(1);
        end
        T_STOP: if (tick) begin
          if (tx_cnt == '0) tx_reg <= 1'b1;
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_2s && tx_n == '0) tx_n  <= 3'd1;
            else                     tx_st <= T_IDLE;
          end else tx_cnt <= tx_cnt + SW'(1);
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: line timing, parity, errors, FIFO limits, reset.
module tb_uart_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] divisor = 16'd1;
  logic data7 = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic rd_uart = 1'b0, wr_uart = 1'b0, err_clr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic rx_drv = 1'b1, ext_loop = 1'b0;
  logic rx, tx, tx_full, rx_empty;
  logic [7:0] r_data;
  logic fe, pe, ov;

  int vecs = 0;
  int errs = 0;

  assign rx = ext_loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg #(.FIFO_W(2), .DIV_W(16), .OVS(16)) dut (
    .clk(clk), .reset(reset), .divisor(divisor), .data7(data7),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .rx(rx),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx), .tx_full(tx_full), .rx_empty(rx_empty), .r_data(r_data),
    .err_clr(err_clr), .rx_frame_err(fe), .rx_parity_err(pe), .rx_overrun(ov)
  );

  task automatic set_cfg(input logic d7, input logic pen, input logic podd, input logic ts);
    @(negedge clk);
    data7 = d7; parity_en = pen; parity_odd = podd; two_stop = ts;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); wr_uart = 1'b1; w_data = b;
    @(negedge clk); wr_uart = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); rd_uart = 1'b1;
    @(negedge clk); rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // Finds the start bit, then records the first-cycle value of each bit and whether it held for bit_clk cycles.
  task automatic capture_frame(input int nbits, input int bit_clk,
                               output logic [15:0] bits, output logic [15:0] stable, output bit found);
    logic first;
    bits = '0; stable = '0; found = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    if (!found) return;
    for (int j = 0; j < nbits; j++) begin
      first = tx;
      stable[j] = 1'b1;
      for (int k = 1; k < bit_clk; k++) begin
        @(negedge clk);
        if (tx !== first) stable[j] = 1'b0;
      end
      bits[j] = first;
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [15:0] bits, input int nbits, input int bit_clk);
    for (int j = 0; j < nbits; j++) begin
      rx_drv = bits[j];
      repeat (bit_clk) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (rx_empty === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b want 1", tx); end
    vecs++; if (tx_full !== 1'b0) begin errs++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    vecs++; if (rx_empty !== 1'b1) begin errs++; $display("FAIL reset_rx_empty got %b want 1", rx_empty); end
    vecs++; if (r_data !== 8'h00) begin errs++; $display("FAIL reset_r_data got %h want 00", r_data); end
    vecs++; if ({fe, pe, ov} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {fe, pe, ov}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8n1_a5();
    logic [15:0] bits, stable;
    bit found, ok;
    ext_loop = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hA5);
    capture_frame(10, 16, bits, stable, found);
    vecs++; if (!found) begin errs++; $display("FAIL a5_start got none want start bit"); end
    vecs++; if (bits[9:0] !== 10'h34A) begin errs++; $display("FAIL a5_bits got %h want 34a", bits[9:0]); end
    vecs++; if (stable[9:0] !== 10'h3FF) begin errs++; $display("FAIL a5_timing got %h want 3ff", stable[9:0]); end
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'hA5) begin errs++; $display("FAIL a5_rx got %h want a5", r_data); end
    vecs++; if ({fe, pe, ov} !== 3'b000) begin errs++; $display("FAIL a5_flags got %b want 000", {fe, pe, ov}); end
    pop();
  endtask

  task automatic test_parity();
    logic [15:0] bits, stable;
    bit found, ok;
    // 8E1 0x03: start, 1,1,0,0,0,0,0,0, parity 0, stop
    set_cfg(1'b0, 1'b1, 1'b0, 1'b0);
    push(8'h03);
    capture_frame(11, 16, bits, stable, found);
    vecs++; if (!found || bits[10:0] !== 11'h406 || stable[10:0] !== 11'h7FF)
      begin errs++; $display("FAIL even_line got %h/%h want 406/7ff", bits[10:0], stable[10:0]); end
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'h03 || pe !== 1'b0)
      begin errs++; $display("FAIL even_rx got %h pe=%b want 03 pe=0", r_data, pe); end
    pop();
    set_cfg(1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h03);
    capture_frame(11, 16, bits, stable, found);
    vecs++; if (!found || bits[10:0] !== 11'h606 || stable[10:0] !== 11'h7FF)
      begin errs++; $display("FAIL odd_line got %h/%h want 606/7ff", bits[10:0], stable[10:0]); end
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'h03 || pe !== 1'b0)
      begin errs++; $display("FAIL odd_rx got %h pe=%b want 03 pe=0", r_data, pe); end
    pop();
    // even config, but the odd-parity frame is driven: parity bit is wrong
    ext_loop = 1'b0;
    set_cfg(1'b0, 1'b1, 1'b0, 1'b0);
    drive_frame(16'h0606, 11, 16);
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'h03) begin errs++; $display("FAIL bad_par_data got %h want 03", r_data); end
    vecs++; if (pe !== 1'b1) begin errs++; $display("FAIL bad_par_flag got %b want 1", pe); end
    vecs++; if (fe !== 1'b0) begin errs++; $display("FAIL bad_par_fe got %b want 0", fe); end
    pop();
    pulse_clr();
    vecs++; if (pe !== 1'b0) begin errs++; $display("FAIL par_clr got %b want 0", pe); end
  endtask

  task automatic test_frame_glitch();
    bit ok;
    ext_loop = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    drive_frame(16'h00AA, 10, 16);
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'h55) begin errs++; $display("FAIL frame_data got %h want 55", r_data); end
    vecs++; if (fe !== 1'b1) begin errs++; $display("FAIL frame_flag got %b want 1", fe); end
    pop();
    repeat (40) @(negedge clk);
    pulse_clr();
    vecs++; if (fe !== 1'b0) begin errs++; $display("FAIL frame_clr got %b want 0", fe); end
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    vecs++; if (rx_empty !== 1'b1) begin errs++; $display("FAIL glitch_empty got %b want 1", rx_empty); end
    vecs++; if (fe !== 1'b0) begin errs++; $display("FAIL glitch_fe got %b want 0", fe); end
  endtask

  task automatic test_overrun_full();
    logic [7:0] expq [4];
    expq = '{8'h11, 8'h22, 8'h33, 8'h44};
    ext_loop = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h11);
    repeat (3) @(negedge clk);
    push(8'h22); push(8'h33); push(8'h44);
    vecs++; if (tx_full !== 1'b0) begin errs++; $display("FAIL full_at3 got %b want 0", tx_full); end
    push(8'h55);
    vecs++; if (tx_full !== 1'b1) begin errs++; $display("FAIL full_at4 got %b want 1", tx_full); end
    push(8'h66);
    vecs++; if (tx_full !== 1'b1) begin errs++; $display("FAIL full_at5 got %b want 1", tx_full); end
    repeat (1100) @(negedge clk);
    vecs++; if (ov !== 1'b1) begin errs++; $display("FAIL overrun got %b want 1", ov); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (rx_empty !== 1'b0 || r_data !== expq[i]) begin
        errs++; $display("FAIL rx_seq%0d got %h empty=%b want %h", i, r_data, rx_empty, expq[i]);
      end
      pop();
    end
    vecs++; if (rx_empty !== 1'b1) begin errs++; $display("FAIL rx_drained got %b want 1", rx_empty); end
    repeat (400) @(negedge clk);
    vecs++; if (rx_empty !== 1'b1) begin errs++; $display("FAIL no_sixth got %b want 1", rx_empty); end
  endtask

  task automatic test_7o2();
    logic [15:0] bits, stable;
    bit found, ok;
    ext_loop = 1'b1;
    set_cfg(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); divisor = 16'd3;
    repeat (10) @(negedge clk);
    push(8'hFF);
    // start, seven ones, parity 0, two stop bits; 48 clk per bit
    capture_frame(11, 48, bits, stable, found);
    vecs++; if (!found || bits[10:0] !== 11'h6FE)
      begin errs++; $display("FAIL 7o2_bits got %h want 6fe", bits[10:0]); end
    vecs++; if (stable[10:0] !== 11'h7FF) begin errs++; $display("FAIL 7o2_timing got %h want 7ff", stable[10:0]); end
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'h7F) begin errs++; $display("FAIL 7o2_rx got %h want 7f", r_data); end
    vecs++; if ({fe, pe} !== 2'b00) begin errs++; $display("FAIL 7o2_flags got %b want 00", {fe, pe}); end
    pop();
    repeat (600) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int lows;
    ext_loop = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); divisor = 16'd1;
    push(8'hC3);
    wait_rx(ok);
    vecs++; if (!ok || r_data !== 8'hC3) begin errs++; $display("FAIL pre_reset_rx got %h want c3", r_data); end
    for (int i = 0; i < 5; i++) push(8'h00);
    vecs++; if (tx_full !== 1'b1) begin errs++; $display("FAIL pre_reset_full got %b want 1", tx_full); end
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vecs++; if (tx !== 1'b1 || tx_full !== 1'b0 || rx_empty !== 1'b1)
      begin errs++; $display("FAIL midreset got tx=%b full=%b empty=%b want 1 0 1", tx, tx_full, rx_empty); end
    vecs++; if ({fe, pe, ov} !== 3'b000) begin errs++; $display("FAIL midreset_flags got %b want 000", {fe, pe, ov}); end
    @(negedge clk); reset = 1'b0;
    lows = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    vecs++; if (lows != 0) begin errs++; $display("FAIL post_reset_tx got %0d low cycles want 0", lows); end
    vecs++; if (rx_empty !== 1'b1) begin errs++; $display("FAIL post_reset_rx got %b want 1", rx_empty); end
  endtask

  initial begin
    test_reset();
    test_8n1_a5();
    test_parity();
    test_frame_glitch();
    test_overrun_full();
    test_7o2();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Runtime-configurable UART with separate receive and transmit FIFOs. Supports a programmable baud divisor, 7/8 data bits, none/even/odd parity, and 1/2 stop bits. Receive errors (framing, parity, overrun) are reported as sticky flags. It is a drop-in successor for host-link serial I/O where the baud rate and frame format are set by software rather than fixed at synthesis.

Parameters:
FIFO_W, 2, log2 of FIFO depth (each FIFO holds 2**FIFO_W bytes)
DIV_W, 16, width of baud divisor input
OVS, 16, oversampling ticks per bit (power of two, 8 or 16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
divisor  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
data7  in  1  1 = 7 data bits, 0 = 8 data bits
parity_en  in  1  enable parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity (used only if parity_en)
two_stop  in  1  1 = two stop bits
rd_uart  in  1  pop one byte from RX FIFO
wr_uart  in  1  push w_data into TX FIFO
w_data  in  8  TX byte (bit 7 ignored in 7-bit mode)
rx  in  1  serial input, asynchronous
tx  out  1  serial output
tx_full  out  1  TX FIFO full
rx_empty  out  1  RX FIFO empty
r_data  out  8  head of RX FIFO (valid while rx_empty=0)
err_clr  in  1  clear all sticky error flags
rx_frame_err  out  1  sticky: stop bit sampled low
rx_parity_err  out  1  sticky: parity mismatch
rx_overrun  out  1  sticky: byte received while RX FIFO full

Behaviour:
- Reset values: tx=1, tx_full=0, rx_empty=1, r_data=0, all error flags 0, both FSMs IDLE, FIFOs empty, baud counter 0.
- Baud generator: counter runs 0..max(divisor,1)-1 and emits a one-cycle tick at the terminal count. A divisor change takes effect on the next wrap.
- Frame config (data7, parity_en, parity_odd, two_stop) is latched per direction at start-bit detection (RX) or byte load (TX). Changes mid-frame have no effect on the frame in progress.
- rx passes through a 2-flop synchroniser before use.
- RX FSM: IDLE -> START on synchronised rx=0.
  - START: count OVS/2 ticks. If rx=1 then, go to IDLE (glitch, nothing written); otherwise go to DATA.
  - DATA: sample every OVS ticks, LSB first, 7 or 8 bits.
  - PARITY (if enabled): one sample.
  - STOP: sample after OVS ticks; if two_stop, wait a further OVS ticks before the next start is accepted.
  - On the STOP sample, write the byte to the RX FIFO in the same cycle. The byte is written even if a framing or parity error occurs; the matching flag is set. In 7-bit mode, stored bit 7 = 0.
- Overrun: RX write while the RX FIFO is full (and no simultaneous rd_uart) drops the new byte and sets rx_overrun.
- err_clr clears the flags. If an error occurs in the same cycle as err_clr, the flag is set (set wins).
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - In IDLE with the TX FIFO non-empty: pop the head byte into a shift register and go to START. Drive tx=0 from the next tick for OVS ticks.
  - Then the data bits LSB first, then parity, then 1 or 2 stop bits (tx=1), each lasting OVS ticks; then return to IDLE.
  - tx is registered.
- FIFOs:
  - Write when full is ignored; read when empty is ignored.
  - Simultaneous rd and wr when full: both take effect (occupancy unchanged).
  - Simultaneous rd and wr when empty: write only.
  - Pointers wrap modulo 2**FIFO_W.
- Parity: even = XOR of the data bits; odd = inverted XOR.

Optional Feature:
UART_LOOPBACK_EN: when defined, adds input port loopback (1 bit, placed after rx).
- loopback=1: the internal RX path takes the registered tx, and the external tx pin is held at 1.
- loopback=0, or macro undefined: normal operation. When undefined, the port does not exist.

Test Plan:
- Assert reset mid-frame while transmitting -> tx=1, rx_empty=1, tx_full=0, flags 0 on the next edge. After release, no residual frame appears on tx.
- divisor=1, OVS=16, 8N1, write 0xA5 -> tx low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high. Total frame 160 clk.
- 8E1, write 0x03, tx externally looped to rx -> parity bit 0 on the line, r_data=0x03, rx_parity_err=0. Repeat 8O1 -> parity bit 1. Force the parity bit inverted -> r_data=0x03, rx_parity_err=1. err_clr -> 0.
- Drive a frame 0x55 with the stop bit low -> r_data=0x55, rx_frame_err=1. Then a rx low pulse of 4 ticks -> nothing written, rx_empty unchanged.
- FIFO_W=2: receive 0x11,0x22,0x33,0x44,0x55 without reading -> rx_overrun=1. Reads return 0x11..0x44, then rx_empty=1. Five writes to the TX FIFO while tx is idle-blocked -> tx_full=1 after the fourth; the fifth is dropped.
- 7O2 with divisor=3, write 0xFF -> 7 data ones, parity 0, two stop bits, 48 clk per bit. Looped-back r_data=0x7F.
